// File: rtl/up_pkg.sv
`default_nettype none
// ============================================================================
// Module   : up_pkg
// Purpose  : Opcode constants and FSM state encodings shared by up_core_v2.
// Revision : 1.0
// ============================================================================
package up_pkg;

    localparam logic [7:0] c_OP_NOP  = 8'h00;
    localparam logic [7:0] c_OP_LDI  = 8'h01;
    localparam logic [7:0] c_OP_LD   = 8'h02;
    localparam logic [7:0] c_OP_ST   = 8'h03;
    localparam logic [7:0] c_OP_ADD  = 8'h04;
    localparam logic [7:0] c_OP_SUB  = 8'h05;
    localparam logic [7:0] c_OP_AND  = 8'h06;
    localparam logic [7:0] c_OP_OR   = 8'h07;
    localparam logic [7:0] c_OP_XOR  = 8'h08;
    localparam logic [7:0] c_OP_JMP  = 8'h09;
    localparam logic [7:0] c_OP_JZ   = 8'h0A;
    localparam logic [7:0] c_OP_JC   = 8'h0B;
    localparam logic [7:0] c_OP_CALL = 8'h0C;
    localparam logic [7:0] c_OP_RET  = 8'h0D;
    localparam logic [7:0] c_OP_RETI = 8'h0E;
    localparam logic [7:0] c_OP_HALT = 8'h0F;
    localparam logic [7:0] c_OP_EI   = 8'h10;
    localparam logic [7:0] c_OP_DI   = 8'h11;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/up_ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : up_ret_stack
// Purpose  : LIFO return-address stack; push+pop together replaces the top.
// Revision : 1.0
// ============================================================================
module up_ret_stack #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_top,
    output logic          o_full,
    output logic          o_empty
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [c_CW-1:0] r_count;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0] w_top_idx;
    logic [c_AW-1:0] w_wr_idx;
    logic            w_replace;
    logic            w_do_push;

    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_top_idx = r_count[c_AW-1:0] - c_AW'(1);
    assign w_replace = i_push && i_pop && !o_empty;
    assign w_do_push = i_push && (w_replace || !o_full);
    assign w_wr_idx  = w_replace ? w_top_idx : r_count[c_AW-1:0];
    assign o_top     = r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_replace) begin
            r_count <= r_count;
        end else if (i_push && !o_full) begin
            r_count <= r_count + c_CW'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/up_core_v2.sv
`default_nettype none
// ============================================================================
// Module   : up_core_v2
// Purpose  : Accumulator micro-core: 2-cycle fetch/exec, return stack, IRQ.
// Revision : 1.0
// ============================================================================
module up_core_v2
    import up_pkg::*;
#(
    parameter int                 WIDTH       = 16,
    parameter int                 PC_BITS     = 8,
    parameter int                 REG_NUM     = 16,
    parameter int                 STACK_DEPTH = 8,
    parameter logic [PC_BITS-1:0] IRQ_VEC     = 8'hF0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    output logic [PC_BITS-1:0]   imem_addr,
    output logic                 imem_req,
    input  logic [8+WIDTH-1:0]   imem_data,
    input  logic                 imem_valid,
    input  logic                 irq,
    output logic [WIDTH-1:0]     acc_out,
    output logic                 zero,
    output logic                 carry,
    output logic                 halted,
    output logic                 stack_err
);

    localparam int c_RW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    state_t               r_state;
    logic [PC_BITS-1:0]   r_pc;
    logic [WIDTH-1:0]     r_acc;
    logic                 r_carry;
    logic                 r_ie;
    logic                 r_err;
    logic [7:0]           r_op;
    logic [WIDTH-1:0]     r_imm;
    logic [WIDTH-1:0]     r_regs [REG_NUM];

    logic [c_RW-1:0]      w_reg_idx;
    logic [WIDTH-1:0]     w_reg_val;
    logic [PC_BITS-1:0]   w_pc_inc;
    logic [PC_BITS-1:0]   w_target;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [PC_BITS-1:0]   w_stack_top;
    logic                 w_full;
    logic                 w_empty;

    logic [PC_BITS-1:0]   w_next_pc;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic                 w_carry_nxt;
    logic                 w_ie_nxt;
    logic                 w_err_set;
    logic                 w_push;
    logic                 w_pop;
    logic [PC_BITS-1:0]   w_push_data;
    logic                 w_halt;
    logic                 w_wake;

    assign w_reg_idx = r_imm[c_RW-1:0];
    assign w_reg_val = r_regs[w_reg_idx];
    assign w_pc_inc  = r_pc + PC_BITS'(1);
    assign w_target  = r_imm[PC_BITS-1:0];
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_reg_val};
    assign w_diff    = {1'b0, r_acc} - {1'b0, w_reg_val};

    up_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .DW    (PC_BITS)
    ) u_ret_stack (
        .clk     (clk_in),
        .rst     (rst_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_top   (w_stack_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next_pc   = w_pc_inc;
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        w_ie_nxt    = r_ie;
        w_err_set   = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_push_data = w_pc_inc;
        w_halt      = 1'b0;
        w_wake      = 1'b0;
        if (r_state == ST_EXEC) begin
            case (r_op)
                c_OP_LDI:  w_acc_nxt = r_imm;
                c_OP_LD:   w_acc_nxt = w_reg_val;
                c_OP_ADD:  {w_carry_nxt, w_acc_nxt} = w_sum;
                c_OP_SUB:  {w_carry_nxt, w_acc_nxt} = w_diff;
                c_OP_AND:  w_acc_nxt = r_acc & w_reg_val;
                c_OP_OR:   w_acc_nxt = r_acc | w_reg_val;
                c_OP_XOR:  w_acc_nxt = r_acc ^ w_reg_val;
                c_OP_JMP:  w_next_pc = w_target;
                c_OP_JZ:   if (r_acc == '0) w_next_pc = w_target;
                c_OP_JC:   if (r_carry) w_next_pc = w_target;
                c_OP_CALL: begin
                    if (w_full) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_push    = 1'b1;
                        w_next_pc = w_target;
                    end
                end
                c_OP_RET, c_OP_RETI: begin
                    if (w_empty) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_pop     = 1'b1;
                        w_next_pc = w_stack_top;
                        if (r_op == c_OP_RETI) w_ie_nxt = 1'b1;
                    end
                end
                c_OP_HALT: w_halt = 1'b1;
                c_OP_EI:   w_ie_nxt = 1'b1;
                c_OP_DI:   w_ie_nxt = 1'b0;
                default:   w_next_pc = w_pc_inc;
            endcase
            // IE sampled before this instruction; a CALL that pushed defers the IRQ one instruction
            if (irq && r_ie && !w_full && !w_push) begin
                w_push      = 1'b1;
                w_push_data = w_next_pc;
                w_next_pc   = IRQ_VEC;
                w_ie_nxt    = 1'b0;
                w_halt      = 1'b0;
            end
        end else if (r_state == ST_HALT) begin
            if (irq && r_ie && !w_full) begin
                w_push      = 1'b1;
                w_push_data = r_pc;
                w_next_pc   = IRQ_VEC;
                w_ie_nxt    = 1'b0;
                w_wake      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_ie    <= 1'b0;
            r_err   <= 1'b0;
            r_op    <= c_OP_NOP;
            r_imm   <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_valid) begin
                        r_op    <= imem_data[8+WIDTH-1:WIDTH];
                        r_imm   <= imem_data[WIDTH-1:0];
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_pc    <= w_next_pc;
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_carry_nxt;
                    r_ie    <= w_ie_nxt;
                    if (w_err_set) r_err <= 1'b1;
                    r_state <= w_halt ? ST_HALT : ST_FETCH;
                end
                ST_HALT: begin
                    if (w_wake) begin
                        r_pc    <= w_next_pc;
                        r_ie    <= w_ie_nxt;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Register file is deliberately left out of reset
    always_ff @(posedge clk_in) begin
        if (!rst_in && r_state == ST_EXEC && r_op == c_OP_ST) begin
            r_regs[w_reg_idx] <= r_acc;
        end
    end

    assign imem_req  = (r_state == ST_FETCH) && !rst_in;
    assign imem_addr = r_pc;
    assign acc_out   = r_acc;
    assign zero      = (r_acc == '0);
    assign carry     = r_carry;
    assign halted    = (r_state == ST_HALT) && !rst_in;
    assign stack_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_up_core_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_core_v2
// Purpose  : Directed program bench for up_core_v2 with a fetch-address scoreboard.
// Revision : 1.0
// ============================================================================
module tb_up_core_v2;
    import up_pkg::*;

    localparam int WIDTH   = 16;
    localparam int PC_BITS = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [PC_BITS-1:0]   imem_addr;
    logic                 imem_req;
    logic [8+WIDTH-1:0]   imem_data;
    logic                 imem_valid;
    logic                 irq = 1'b0;
    logic [WIDTH-1:0]     acc_out;
    logic                 zero;
    logic                 carry;
    logic                 halted;
    logic                 stack_err;

    logic [8+WIDTH-1:0]   prog [256];
    int                   wait_states = 0;
    int                   stall_addr  = -1;
    int                   wcnt        = 0;
    int                   n_pass      = 0;
    int                   n_total     = 0;
    logic [31:0]          exp_q [$];
    logic [31:0]          mon_exp;
    logic                 prev_req   = 1'b0;
    logic                 prev_valid = 1'b0;
    logic [PC_BITS-1:0]   prev_addr  = '0;

    always #5 clk = ~clk;

    up_core_v2 dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .irq        (irq),
        .acc_out    (acc_out),
        .zero       (zero),
        .carry      (carry),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    // Instruction memory with programmable wait states and a per-address stall
    always @(posedge clk) begin
        if (rst || !imem_req || imem_valid) wcnt <= 0;
        else                                wcnt <= wcnt + 1;
    end
    assign imem_valid = imem_req && (wcnt >= wait_states) && (int'(imem_addr) != stall_addr);
    assign imem_data  = prog[imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [23:0] ins(input logic [7:0] op, input logic [15:0] imm);
        return {op, imm};
    endfunction

    // Scoreboard: every accepted fetch must match the next expected address
    always @(negedge clk) begin
        if (!rst && imem_req && imem_valid) begin
            mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check("fetch_addr", {24'h0, imem_addr}, mon_exp);
        end
        if (!rst && prev_req && !prev_valid && imem_req)
            check("hold_addr", {24'h0, imem_addr}, {24'h0, prev_addr});
        prev_req   <= imem_req;
        prev_valid <= imem_valid;
        prev_addr  <= imem_addr;
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = '0;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'h0, halted}, 32'h1);
    endtask

    task automatic expect_fetches(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) exp_q.push_back(a);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state plus add/carry program
        clear_prog();
        prog[0] = ins(c_OP_LDI, 16'h0005);
        prog[1] = ins(c_OP_ST,  16'h0001);
        prog[2] = ins(c_OP_LDI, 16'hFFFF);
        prog[3] = ins(c_OP_ADD, 16'h0001);
        prog[4] = ins(c_OP_JC,  16'h0008);
        prog[8] = ins(c_OP_HALT, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",    {31'h0, imem_req},   32'h0);
        check("rst_halted", {31'h0, halted},     32'h0);
        check("rst_acc",    {16'h0, acc_out},    32'h0);
        check("rst_carry",  {31'h0, carry},      32'h0);
        check("rst_zero",   {31'h0, zero},       32'h1);
        check("rst_err",    {31'h0, stack_err},  32'h0);
        check("rst_addr",   {24'h0, imem_addr},  32'h0);
        expect_fetches(0, 4);
        exp_q.push_back(8);
        @(posedge clk); #1 rst = 1'b0;
        wait_halt("a_halt");
        check("a_acc",   {16'h0, acc_out}, 32'h0004);
        check("a_carry", {31'h0, carry},   32'h1);
        check("a_zero",  {31'h0, zero},    32'h0);
        check("a_drain", exp_q.size(),     32'h0);

        // SUB borrow, logic ops keep carry, undefined opcode, JZ, index masking
        clear_prog();
        prog[0]  = ins(c_OP_LDI, 16'h0003);
        prog[1]  = ins(c_OP_ST,  16'h0012);
        prog[2]  = ins(c_OP_LDI, 16'h0002);
        prog[3]  = ins(c_OP_SUB, 16'h0002);
        prog[4]  = ins(c_OP_LDI, 16'h00F0);
        prog[5]  = ins(c_OP_AND, 16'h0002);
        prog[6]  = ins(c_OP_OR,  16'h0012);
        prog[7]  = ins(c_OP_XOR, 16'h0002);
        prog[8]  = ins(8'h55,    16'h1234);
        prog[9]  = ins(c_OP_JZ,  16'h000C);
        prog[10] = ins(c_OP_LDI, 16'hDEAD);
        prog[12] = ins(c_OP_LD,  16'h0022);
        prog[13] = ins(c_OP_HALT, 16'h0000);
        expect_fetches(0, 9);
        expect_fetches(12, 13);
        reset_pulse();
        wait_halt("b_halt");
        check("b_acc",   {16'h0, acc_out}, 32'h0003);
        check("b_carry", {31'h0, carry},   32'h1);
        check("b_zero",  {31'h0, zero},    32'h0);
        check("b_drain", exp_q.size(),     32'h0);

        // Wait states: request held stable, branch target fetched
        clear_prog();
        prog[0]    = ins(c_OP_LDI, 16'h0000);
        prog[1]    = ins(c_OP_JZ,  16'h0020);
        prog[8'h20] = ins(c_OP_HALT, 16'h0000);
        wait_states = 3;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(32'h20);
        reset_pulse();
        wait_halt("c_halt");
        check("c_zero",  {31'h0, zero}, 32'h1);
        check("c_drain", exp_q.size(),  32'h0);
        wait_states = 0;

        // CALL / RET round trip
        clear_prog();
        prog[0]     = ins(c_OP_JMP,  16'h0010);
        prog[8'h10] = ins(c_OP_CALL, 16'h0040);
        prog[8'h40] = ins(c_OP_RET,  16'h0000);
        prog[8'h11] = ins(c_OP_HALT, 16'h0000);
        exp_q.push_back(0); exp_q.push_back(32'h10);
        exp_q.push_back(32'h40); exp_q.push_back(32'h11);
        reset_pulse();
        wait_halt("d1_halt");
        check("d1_err",   {31'h0, stack_err}, 32'h0);
        check("d1_drain", exp_q.size(),       32'h0);

        // Nested CALLs overflow the stack; the last one falls through
        clear_prog();
        for (int i = 0; i < 8; i++) prog[i] = ins(c_OP_CALL, 16'(i + 1));
        prog[8] = ins(c_OP_CALL, 16'h0030);
        prog[9] = ins(c_OP_HALT, 16'h0000);
        expect_fetches(0, 9);
        reset_pulse();
        wait_halt("d2_halt");
        check("d2_err",   {31'h0, stack_err}, 32'h1);
        check("d2_drain", exp_q.size(),       32'h0);

        // RET on empty stack
        clear_prog();
        prog[0] = ins(c_OP_RET,  16'h0000);
        prog[1] = ins(c_OP_HALT, 16'h0000);
        expect_fetches(0, 1);
        reset_pulse();
        wait_halt("e_halt");
        check("e_err",   {31'h0, stack_err}, 32'h1);
        check("e_drain", exp_q.size(),       32'h0);

        // Wake from HALT on IRQ, RETI restores IE
        clear_prog();
        prog[0]     = ins(c_OP_EI,   16'h0000);
        prog[5]     = ins(c_OP_HALT, 16'h0000);
        prog[8'hF0] = ins(c_OP_RETI, 16'h0000);
        prog[6]     = ins(c_OP_LDI,  16'h0077);
        prog[7]     = ins(c_OP_HALT, 16'h0000);
        prog[8]     = ins(c_OP_HALT, 16'h0000);
        expect_fetches(0, 5);
        exp_q.push_back(32'hF0); exp_q.push_back(6); exp_q.push_back(7);
        exp_q.push_back(32'hF0); exp_q.push_back(8);
        reset_pulse();
        wait_halt("f_halt5");
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1 irq = 1'b1;
            begin
                int n = 0;
                while (halted && n < 20) begin
                    @(negedge clk);
                    n++;
                end
            end
            check("f_wake", {31'h0, halted}, 32'h0);
            @(posedge clk); #1 irq = 1'b0;
            wait_halt("f_rehalt");
        end
        check("f_acc",   {16'h0, acc_out}, 32'h0077);
        check("f_drain", exp_q.size(),     32'h0);

        // EI with IRQ already high: interrupt taken one instruction later
        clear_prog();
        prog[0]     = ins(c_OP_EI,   16'h0000);
        prog[8'hF0] = ins(c_OP_HALT, 16'h0000);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(32'hF0);
        irq = 1'b1;
        reset_pulse();
        wait_halt("g_halt");
        repeat (5) @(negedge clk);
        check("g_stay_halted", {31'h0, halted}, 32'h1);
        check("g_drain",       exp_q.size(),    32'h0);
        @(posedge clk); #1 irq = 1'b0;

        // Reset while a fetch is stalled
        clear_prog();
        prog[0] = ins(c_OP_LDI, 16'hABCD);
        prog[1] = ins(c_OP_RET, 16'h0000);
        stall_addr = 2;
        expect_fetches(0, 1);
        reset_pulse();
        begin
            int n = 0;
            while (!stack_err && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (3) @(negedge clk);
        check("h_req_pending", {31'h0, imem_req},  32'h1);
        check("h_addr_pend",   {24'h0, imem_addr}, 32'h2);
        check("h_acc_pre",     {16'h0, acc_out},   32'hABCD);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("h_rst_req",    {31'h0, imem_req}, 32'h0);
        check("h_rst_halted", {31'h0, halted},   32'h0);
        prog[0] = ins(c_OP_HALT, 16'h0000);
        stall_addr = -1;
        exp_q.push_back(0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("h_addr0", {24'h0, imem_addr}, 32'h0);
        check("h_acc0",  {16'h0, acc_out},   32'h0);
        check("h_err0",  {31'h0, stack_err}, 32'h0);
        wait_halt("h_halt");
        check("h_drain", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
